// File: rtl/guess_scoreboard.sv
// Win/loss BCD tallies fed by the game FSM's win/lose levels, multiplexed onto
// a 4-digit active-low 7-segment display.
module guess_scoreboard #(
  parameter int REFRESH_DIV = 100_000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       win,
  input  logic       lose,
  input  logic       clr_scores,
  output logic [7:0] win_bcd,
  output logic [7:0] lose_bcd,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       GLYPH_0  = 7'b1000000;

  logic             win_prev_q, lose_prev_q;
  logic             win_evt_q, lose_evt_q;
  logic             win_evt_d, lose_evt_d;
  logic [7:0]       win_q, win_d;
  logic [7:0]       lose_q, lose_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       digit;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd9) r = 8'h00;
      else                r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Events are registered first, so a tally moves one edge after the rising
  // level is sampled; a clear kills both the pending and the arriving event.
  always_comb begin
    win_evt_d  = win  & ~win_prev_q  & ~clr_scores;
    lose_evt_d = lose & ~lose_prev_q & ~clr_scores;

    win_d  = win_q;
    lose_d = lose_q;
    if (clr_scores) begin
      win_d  = 8'h00;
      lose_d = 8'h00;
    end else begin
      if (win_evt_q)  win_d  = bcd_inc(win_q);
      if (lose_evt_q) lose_d = bcd_inc(lose_q);
    end
  end

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Anode and glyph are both derived from idx_q and registered together.
  always_comb begin
    an_d  = 4'b1110;
    digit = lose_q[3:0];
    case (idx_q)
      2'd0: begin an_d = 4'b1110; digit = lose_q[3:0]; end
      2'd1: begin an_d = 4'b1101; digit = lose_q[7:4]; end
      2'd2: begin an_d = 4'b1011; digit = win_q[3:0];  end
      2'd3: begin an_d = 4'b0111; digit = win_q[7:4];  end
      default: ;
    endcase
    seg_d = seg_decode(digit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_prev_q  <= 1'b1;
      lose_prev_q <= 1'b1;
      win_evt_q   <= 1'b0;
      lose_evt_q  <= 1'b0;
      win_q       <= 8'h00;
      lose_q      <= 8'h00;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      an_q        <= 4'b1110;
      seg_q       <= GLYPH_0;
    end else begin
      win_prev_q  <= win;
      lose_prev_q <= lose;
      win_evt_q   <= win_evt_d;
      lose_evt_q  <= lose_evt_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign win_bcd  = win_q;
  assign lose_bcd = lose_q;
  assign seg      = seg_q;
  assign an       = an_q;

endmodule

// File: tb/tb_guess_scoreboard.sv
// Directed checks of tally edge detection, BCD wrap, clear priority,
// display multiplexing and mid-operation reset.
module tb_guess_scoreboard;

  logic       clk = 1'b0;
  logic       reset, win, lose, clr_scores;
  logic [7:0] win_bcd, lose_bcd;
  logic [6:0] seg;
  logic [3:0] an;

  int checks   = 0;
  int failures = 0;

  guess_scoreboard #(.REFRESH_DIV(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .win        (win),
    .lose       (lose),
    .clr_scores (clr_scores),
    .win_bcd    (win_bcd),
    .lose_bcd   (lose_bcd),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [3:0] an_exp [4];
  logic [6:0] seg_exp[4];
  logic [3:0] prev_an;
  bit         found;

  initial begin
    an_exp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_exp = '{7'b1111000, 7'b1111001, 7'b0100100, 7'b0011001}; // 7,1,2,4

    // 1: level held high across reset is not counted
    reset = 1'b1; win = 1'b1; lose = 1'b0; clr_scores = 1'b0;
    repeat (3) tick();
    chk("rst_win_bcd", win_bcd, 8'h00);
    chk("rst_lose_bcd", lose_bcd, 8'h00);
    chk("rst_an", {4'h0, an}, 8'h0E);
    chk("rst_seg", {1'b0, seg}, 8'h40);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("held_win_no_count", win_bcd, 8'h00);
    end

    // 2: three 5-clk win pulses, each counted one clk after the sampled rise
    win = 1'b0;
    tick();
    for (int k = 1; k <= 3; k++) begin
      win = 1'b1;
      tick();
      chk("win_latency_old", win_bcd, 8'(k - 1));
      tick();
      chk("win_latency_new", win_bcd, 8'(k));
      repeat (3) tick();
      chk("win_held_once", win_bcd, 8'(k));
      win = 1'b0;
      repeat (3) tick();
    end
    chk("win_total", win_bcd, 8'h03);

    // 3: lose BCD carry and 99->00 wrap
    for (int p = 1; p <= 100; p++) begin
      lose = 1'b1; tick();
      lose = 1'b0; tick();
      if (p == 9)   chk("lose_09", lose_bcd, 8'h09);
      if (p == 10)  chk("lose_10", lose_bcd, 8'h10);
      if (p == 99)  chk("lose_99", lose_bcd, 8'h99);
      if (p == 100) chk("lose_wrap_00", lose_bcd, 8'h00);
    end
    chk("win_untouched", win_bcd, 8'h03);

    // 4: simultaneous events, then clear beats a same-cycle event
    win = 1'b1; lose = 1'b1; tick();
    win = 1'b0; lose = 1'b0; tick();
    chk("both_win", win_bcd, 8'h04);
    chk("both_lose", lose_bcd, 8'h01);
    win = 1'b1; clr_scores = 1'b1; tick();
    chk("clr_win", win_bcd, 8'h00);
    chk("clr_lose", lose_bcd, 8'h00);
    clr_scores = 1'b0; win = 1'b0; tick();
    tick();
    chk("clr_drop_evt", win_bcd, 8'h00);

    // 5: preload 42/17 and walk the display scan
    for (int i = 0; i < 42; i++) begin
      win = 1'b1; lose = (i < 17); tick();
      win = 1'b0; lose = 1'b0;     tick();
    end
    tick();
    chk("pre_win_42", win_bcd, 8'h42);
    chk("pre_lose_17", lose_bcd, 8'h17);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev_an = an;
      tick();
      if (an == 4'b1110 && prev_an != 4'b1110) found = 1'b1;
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL scan_start observed=%b expected=%b", found, 1'b1);
    end
    if (found) begin
      for (int i = 0; i < 16; i++) begin
        chk("scan_an", {4'h0, an}, {4'h0, an_exp[i/4]});
        chk("scan_seg", {1'b0, seg}, {1'b0, seg_exp[i/4]});
        chk("scan_onehot", 8'($countones(~an)), 8'd1);
        tick();
      end
    end

    // 6: reset mid-scan with a pending win edge
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (an == 4'b1011) found = 1'b1;
      else tick();
    end
    checks++;
    assert (found) else begin
      failures++;
      $error("FAIL reach_idx2 observed=%b expected=%b", found, 1'b1);
    end
    reset = 1'b1; win = 1'b1; tick();
    reset = 1'b0;
    chk("mid_rst_win", win_bcd, 8'h00);
    chk("mid_rst_lose", lose_bcd, 8'h00);
    chk("mid_rst_an", {4'h0, an}, 8'h0E);
    chk("mid_rst_seg", {1'b0, seg}, 8'h40);
    tick(); tick();
    chk("pending_discarded", win_bcd, 8'h00);
    win = 1'b0; tick();
    win = 1'b1; tick();
    chk("resume_old", win_bcd, 8'h00);
    tick();
    chk("resume_new", win_bcd, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
